// File: rtl/dmem_arbiter_pkg.sv
// ============================================================================
// Module   : dmem_arbiter_pkg
// Brief    : Shared port ids and FSM state encoding for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arbiter_pkg;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_EXT = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_arb_rr2.sv
// ============================================================================
// Module   : arb_rr2
// Brief    : Combinational two-way round-robin picker (CPU vs external port).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_rr2
  import dmem_arbiter_pkg::*;
(
  input  logic req_cpu,
  input  logic req_ext,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  logic w_tie;

  assign w_tie = req_cpu & req_ext;
  assign valid = req_cpu | req_ext;

  // On a tie the port that did not win last time goes next
  assign winner = w_tie ? ((last_gnt == ARB_CPU) ? ARB_EXT : ARB_CPU)
                        : (req_ext ? ARB_EXT : ARB_CPU);

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Round-robin arbiter sharing a single-port synchronous data RAM
//            between the CPU load/store path and an external port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
)(
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rdy,
  output logic [DATA_W-1:0] ext_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] c_CNT_INIT = 2'(MEM_LAT - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic       r_last_gnt;
  logic       r_owner;
  logic [1:0] r_cnt;

  logic       w_valid;
  logic       w_winner;
  logic       w_take;
  logic       w_done;
  logic       w_cpu_gnt_nxt;
  logic       w_ext_gnt_nxt;
  logic       w_cpu_rdy_nxt;
  logic       w_ext_rdy_nxt;

  arb_rr2 u_rr2 (
    .req_cpu  (cpu_req),
    .req_ext  (ext_req),
    .last_gnt (r_last_gnt),
    .valid    (w_valid),
    .winner   (w_winner)
  );

  assign w_done = (r_state == ARB_WAIT) && (r_cnt == 2'd0);

  // Requests are only looked at on the edges leaving IDLE or RESP
  always_comb begin
    w_take      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        w_take = w_valid;
        if (w_valid) w_state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: w_state_nxt = ARB_WAIT;
      ARB_WAIT:  if (r_cnt == 2'd0) w_state_nxt = ARB_RESP;
      ARB_RESP: begin
        w_take      = w_valid;
        w_state_nxt = w_valid ? ARB_ISSUE : ARB_IDLE;
      end
      default:   w_state_nxt = ARB_IDLE;
    endcase

    w_cpu_gnt_nxt = w_take && (w_winner == ARB_CPU);
    w_ext_gnt_nxt = w_take && (w_winner == ARB_EXT);
    w_cpu_rdy_nxt = w_done && (r_owner == ARB_CPU);
    w_ext_rdy_nxt = w_done && (r_owner == ARB_EXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The mem_* output registers double as the request latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_gnt <= ARB_EXT;
      r_owner    <= ARB_CPU;
      r_cnt      <= 2'd0;
      cpu_gnt    <= 1'b0;
      ext_gnt    <= 1'b0;
      cpu_rdy    <= 1'b0;
      ext_rdy    <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      cpu_gnt <= w_cpu_gnt_nxt;
      ext_gnt <= w_ext_gnt_nxt;
      cpu_rdy <= w_cpu_rdy_nxt;
      ext_rdy <= w_ext_rdy_nxt;
      mem_en  <= w_take;

      if (w_take) begin
        r_owner    <= w_winner;
        r_last_gnt <= w_winner;
        mem_we     <= (w_winner == ARB_EXT) ? ext_we    : cpu_we;
        mem_addr   <= (w_winner == ARB_EXT) ? ext_addr  : cpu_addr;
        mem_wdata  <= (w_winner == ARB_EXT) ? ext_wdata : cpu_wdata;
      end

      if (r_state == ARB_ISSUE)
        r_cnt <= c_CNT_INIT;
      else if ((r_state == ARB_WAIT) && (r_cnt != 2'd0))
        r_cnt <= r_cnt - 2'd1;

      if (w_done && !mem_we) begin
        if (r_owner == ARB_CPU) cpu_rdata <= mem_rdata;
        else                    ext_rdata <= mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter sharing the single-port synchronous data memory between the CPU load/store path and an external port (program loader / debug DMA). It accepts one access at a time, sequences the memory enable and read-latency wait, and returns a completion pulse with registered read data to the granted requester. It sits between the control-unit-driven datapath memory interface and the data RAM.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- MEM_LAT, 1, RAM read latency in cycles (legal 1..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle pulse, request accepted
- cpu_rdy  out  1  one-cycle pulse, access complete
- cpu_rdata  out  DATA_W  last read result for CPU
- ext_req, ext_we, ext_addr, ext_wdata, ext_gnt, ext_rdy, ext_rdata: same as cpu_*, for the external port
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid MEM_LAT cycles after the enable edge

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Decision points are the clock edges that end IDLE and RESP. At these edges req inputs are sampled. Requests in ISSUE or WAIT are ignored.
- Arbitration:
  - If one requester is active, it wins.
  - If both are active, the winner is the port not granted last (last_gnt pointer).
  - Reset pointer = ext, so the CPU wins the first tie.
  - The pointer updates on every grant.
- On grant, the winner's we/addr/wdata are latched and the FSM moves to ISSUE.
- ISSUE (1 cycle): winner's gnt=1, mem_en=1, mem_we/mem_addr/mem_wdata driven from the latch. Next state is WAIT.
- WAIT: counter runs from MEM_LAT-1 down to 0, one cycle per count (MEM_LAT cycles). mem_en=0. At count 0 the next state is RESP.
- Transition to RESP:
  - For a read, mem_rdata is captured into the winner's rdata register.
  - For a write, rdata is unchanged.
- RESP (1 cycle): winner's rdy=1. This is also a decision cycle: if any req is sampled, next state is ISSUE; otherwise IDLE.
- Requester rules:
  - A requester must deassert req in the cycle after gnt unless it wants a back-to-back access.
  - A req still high at the end of RESP is a new request.
- A req dropped before gnt is legal. It is simply not granted and has no side effects.
- Each rdata register holds its value until that port's next read completes.
- mem_addr/mem_wdata/mem_we hold their last values outside ISSUE. Only mem_en qualifies them.

## Timing
- Reset (asynchronous, any state including mid-access):
  - state=IDLE, all gnt/rdy/mem_en/mem_we = 0, mem_addr/mem_wdata = 0, rdata regs = 0, last_gnt = ext, counter = 0.
  - An in-flight access is abandoned with no rdy.
- req sampled at edge t0 → gnt and mem_en high in cycle t0..t1 → rdy high in cycle t1+MEM_LAT..t1+MEM_LAT+1.
- gnt-to-rdy distance is MEM_LAT+1 cycles.
- Throughput: one access per MEM_LAT+2 cycles under continuous load (ISSUE + MEM_LAT WAIT + RESP). Consecutive accesses therefore complete MEM_LAT+2 cycles apart.
- Under continuous contention from both ports, grants strictly alternate.
- gnt and rdy are never high for both ports in the same cycle.
- gnt and rdy are never high for the same port in the same cycle.

## Structure
- Add to constants.v:
  - port ids `ARB_CPU=1'b0, `ARB_EXT=1'b1
  - state encodings `ARB_IDLE, `ARB_ISSUE, `ARB_WAIT, `ARB_RESP (2 bits)
- Sub-module arb_rr2: combinational 2-way round-robin picker.
  - Inputs: two requests and last_gnt.
  - Outputs: valid and winner id.
  - Instantiated once by dmem_arbiter.
- The FSM, latency counter, request latch and rdata registers live in dmem_arbiter.

## Test plan
- CPU read alone, MEM_LAT=1, RAM[0x10]=0xBEEF: cpu_req at t0 → cpu_gnt and mem_en cycle 1 with mem_addr=0x10, mem_we=0 → cpu_rdy cycle 3, cpu_rdata=0xBEEF; ext outputs stay 0.
- Ext write then CPU read of same address, ext_wdata=0x1234 to 0x20: ext_rdy pulse, ext_rdata unchanged; subsequent CPU read returns 0x1234.
- Both req high continuously from reset, MEM_LAT=2: grant order CPU, EXT, CPU, EXT; each rdy follows its gnt by 3 cycles; consecutive grants 4 cycles apart; never two gnts in one cycle.
- Back-to-back: CPU holds cpu_req through RESP, ext idle → second cpu_gnt in the cycle immediately after the first cpu_rdy.
- Withdrawn request: ext_req pulses only during WAIT of a CPU access → no ext_gnt, no extra mem_en.
- rst asserted during WAIT → outputs 0 immediately (asynchronous), no rdy for the aborted access; a CPU request after release is granted first on a tie.
